memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  Pipeline stage directly downstream of the ALU stage: consumes the registered ALU result and operands,
//  performs data-memory / stack accesses (load, store, push, pop, call, ret, interrupt entry) on a
//  private word-addressed RAM with its own stack pointer, and registers write-back info for the WB stage.
//  Multi-cycle INT entry stalls upstream stages for one extra cycle.
// PARAMETERS
//  ADDR_W   11   data RAM address width; DEPTH = 2**ADDR_W words of 16 bits
//  SP_INIT  2**ADDR_W-1   stack pointer reset value (stack grows down)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  in_valid     in   1       instruction present in this stage this cycle
//  mem_op       in   3       0 NOP,1 LOAD,2 STORE,3 PUSH,4 POP,5 CALL,6 RET,7 INT
//  alu_result   in   16      ALU output: address for LOAD/STORE, pass-through data otherwise
//  store_data   in   16      data for STORE/PUSH
//  pc_in        in   16      return PC for CALL/INT
//  flags_in     in   3       {carry,zero,neg} saved on INT
//  wb_en_in     in   1       instruction writes a register
//  wb_addr_in   in   3       destination register
//  stall        out  1       upstream must hold its outputs stable this cycle
//  wb_valid     out  1       registered: wb_data/wb_addr valid
//  wb_en        out  1       registered write enable
//  wb_addr      out  3       registered destination register
//  wb_data      out  16      registered: RAM data for LOAD/POP, else alu_result
//  pc_load      out  1       registered 1-cycle pulse: redirect PC to pc_target (RET)
//  pc_target    out  16      registered popped PC
//  sp_out       out  ADDR_W  current stack pointer (debug/forwarding)
//  stack_err    out  1       sticky: SP wrapped (push at 0 or pop at DEPTH-1)
// BEHAVIOUR
//  Reset (async, rst_n=0): sp=SP_INIT; wb_valid, wb_en, pc_load, stall, stack_err=0; wb_addr, wb_data, pc_target=0;
//   FSM -> IDLE. RAM contents not reset.
//  Latency: all outputs except stall registered; result appears on cycle after in_valid is sampled.
//  Addresses: alu_result[ADDR_W-1:0]; upper bits ignored. SP arithmetic modulo DEPTH.
//  LOAD  wb_data=mem[addr].  STORE mem[addr]=store_data, wb_en forced 0.
//  PUSH  mem[sp]=store_data; sp-=1.   POP  sp+=1; wb_data=mem[sp+1] (new sp).
//  CALL  mem[sp]=pc_in; sp-=1.        RET  sp+=1; pc_target=mem[sp+1]; pc_load=1 for one cycle.
//  INT   two cycles: IDLE: mem[sp]=pc_in, sp-=1, latch flags_in, stall=1 (combinational, same cycle), -> INT2;
//        INT2: mem[sp]={13'b0,flags_latched}, sp-=1, stall=0, -> IDLE. wb_valid pulses once, after INT2.
//  FSM states: IDLE, INT2. Only INT leaves IDLE. Inputs are ignored in INT2 (upstream held by stall).
//  in_valid=0 or NOP: no RAM/SP change; wb_valid=0, pc_load=0 next cycle.
//  Store-then-load same address in consecutive cycles returns the new data (RAM write precedes next read).
//  Wrap: PUSH/CALL/INT at sp=0 -> sp=DEPTH-1, stack_err=1; POP/RET at sp=DEPTH-1 -> sp=0, stack_err=1.
//  stack_err clears only on reset. Reset mid-INT: INT2 abandoned, second word not written.
// STRUCTURE
//  Shared package/header: mem_op encodings (MEM_NOP..MEM_INT), flag bit positions, ADDR_W default.
//  One sub-module: data_ram (single-port, sync write, async read, ADDR_W x 16). FSM + SP in top.
// TESTING
//  Reset: rst_n low mid-cycle -> all outputs zero immediately, sp_out=2047.
//  STORE alu_result=0x0010 data=0xBEEF, then LOAD 0x0010 wb_addr_in=3 -> wb_data=0xBEEF, wb_addr=3, wb_valid=1.
//  PUSH 0x1234, PUSH 0x5678, POP, POP -> wb_data 0x5678 then 0x1234; sp_out back to 2047.
//  CALL pc_in=0x0040 then RET -> pc_load one-cycle pulse, pc_target=0x0040, sp restored.
//  INT pc_in=0x0100 flags=3'b101 -> stall high exactly 1 cycle; mem[2047]=0x0100, mem[2046]=0x0005, sp=2045.
//  POP at reset sp -> sp=0, stack_err=1 and stays 1 through later NOPs until reset.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared encodings, widths and helpers for the memory pipeline stage.
package memory_stage_pkg;

  localparam int ADDR_W_DEFAULT = 11;
  localparam int DATA_W         = 16;
  localparam int FLAG_W         = 3;

  localparam int FLAG_NEG   = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_CARRY = 2;

  typedef enum logic [2:0] {
    MEM_NOP   = 3'd0,
    MEM_LOAD  = 3'd1,
    MEM_STORE = 3'd2,
    MEM_PUSH  = 3'd3,
    MEM_POP   = 3'd4,
    MEM_CALL  = 3'd5,
    MEM_RET   = 3'd6,
    MEM_INT   = 3'd7
  } mem_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INT2 = 1'b1
  } state_e;

  // Stack image of the saved flags: {carry,zero,neg} in the low bits.
  function automatic logic [DATA_W-1:0] flags_word(input logic [FLAG_W-1:0] f);
    logic [DATA_W-1:0] w;
    w             = '0;
    w[FLAG_CARRY] = f[FLAG_CARRY];
    w[FLAG_ZERO]  = f[FLAG_ZERO];
    w[FLAG_NEG]   = f[FLAG_NEG];
    return w;
  endfunction

endpackage

// File: rtl/memory_stage_data_ram.sv
// Single-port data RAM: synchronous write, asynchronous read, contents not reset.
module data_ram
  import memory_stage_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: data/stack accesses on a private RAM, stack pointer,
// two-cycle interrupt entry and registered write-back outputs.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int SP_INIT = 2**ADDR_W - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [2:0]        mem_op,
  input  logic [15:0]       alu_result,
  input  logic [15:0]       store_data,
  input  logic [15:0]       pc_in,
  input  logic [2:0]        flags_in,
  input  logic              wb_en_in,
  input  logic [2:0]        wb_addr_in,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [2:0]        wb_addr,
  output logic [15:0]       wb_data,
  output logic              pc_load,
  output logic [15:0]       pc_target,
  output logic [ADDR_W-1:0] sp_out,
  output logic              stack_err
);

  localparam logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_INIT);
  localparam logic [ADDR_W-1:0] SP_TOP   = '1;

  state_e              state;
  mem_op_e             op;
  logic [ADDR_W-1:0]   sp;
  logic [ADDR_W-1:0]   sp_inc;
  logic [ADDR_W-1:0]   sp_dec;
  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_we;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;
  logic [FLAG_W-1:0]   flags_q;
  logic                int_wb_en;
  logic                accept;
  logic                push_like;
  logic                pop_like;

  assign op        = mem_op_e'(mem_op);
  assign sp_inc    = sp + ADDR_W'(1);
  assign sp_dec    = sp - ADDR_W'(1);
  assign sp_out    = sp;
  assign accept    = in_valid && (state == ST_IDLE);
  assign stall     = rst_n && accept && (op == MEM_INT);
  // The second INT cycle is a push of the latched flags regardless of inputs.
  assign push_like = (state == ST_INT2) ||
                     (accept && (op == MEM_PUSH || op == MEM_CALL || op == MEM_INT));
  assign pop_like  = accept && (op == MEM_POP || op == MEM_RET);

  always_comb begin
    ram_we    = push_like || (accept && op == MEM_STORE);
    ram_addr  = sp;
    ram_wdata = store_data;
    if (state == ST_INT2) begin
      ram_wdata = flags_word(flags_q);
    end else if (accept) begin
      case (op)
        MEM_LOAD, MEM_STORE: ram_addr  = alu_result[ADDR_W-1:0];
        MEM_POP, MEM_RET:    ram_addr  = sp_inc;
        MEM_CALL, MEM_INT:   ram_wdata = pc_in;
        default:             ;
      endcase
    end
  end

  data_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sp        <= SP_RESET;
      flags_q   <= '0;
      int_wb_en <= 1'b0;
      wb_valid  <= 1'b0;
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      pc_load   <= 1'b0;
      pc_target <= '0;
      stack_err <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_en    <= 1'b0;
      pc_load  <= 1'b0;
      if (push_like) begin
        sp <= sp_dec;
        if (sp == '0) stack_err <= 1'b1;
      end else if (pop_like) begin
        sp <= sp_inc;
        if (sp == SP_TOP) stack_err <= 1'b1;
      end
      // INT captures its write-back fields up front and publishes them after INT2.
      if (state == ST_INT2) begin
        state    <= ST_IDLE;
        wb_valid <= 1'b1;
        wb_en    <= int_wb_en;
      end else if (accept && op != MEM_NOP) begin
        wb_addr <= wb_addr_in;
        wb_data <= (op == MEM_LOAD || op == MEM_POP) ? ram_rdata : alu_result;
        if (op == MEM_INT) begin
          state     <= ST_INT2;
          flags_q   <= flags_in;
          int_wb_en <= wb_en_in;
        end else begin
          wb_valid <= 1'b1;
          wb_en    <= wb_en_in && (op != MEM_STORE);
        end
        if (op == MEM_RET) begin
          pc_load   <= 1'b1;
          pc_target <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: behavioural stack/RAM model plus directed literal checks.
module tb_memory_stage;

  localparam int AW            = 11;
  localparam int DEPTH         = 2048;
  localparam int RANDOM_CYCLES = 3000;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_PUSH  = 3'd3;
  localparam logic [2:0] OP_POP   = 3'd4;
  localparam logic [2:0] OP_CALL  = 3'd5;
  localparam logic [2:0] OP_RET   = 3'd6;
  localparam logic [2:0] OP_INT   = 3'd7;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b1;
  logic          in_valid   = 1'b0;
  logic [2:0]    mem_op     = '0;
  logic [15:0]   alu_result = '0;
  logic [15:0]   store_data = '0;
  logic [15:0]   pc_in      = '0;
  logic [2:0]    flags_in   = '0;
  logic          wb_en_in   = 1'b0;
  logic [2:0]    wb_addr_in = '0;
  logic          stall;
  logic          wb_valid;
  logic          wb_en;
  logic [2:0]    wb_addr;
  logic [15:0]   wb_data;
  logic          pc_load;
  logic [15:0]   pc_target;
  logic [AW-1:0] sp_out;
  logic          stack_err;

  memory_stage #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .mem_op     (mem_op),
    .alu_result (alu_result),
    .store_data (store_data),
    .pc_in      (pc_in),
    .flags_in   (flags_in),
    .wb_en_in   (wb_en_in),
    .wb_addr_in (wb_addr_in),
    .stall      (stall),
    .wb_valid   (wb_valid),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .sp_out     (sp_out),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   checking = 1'b0;
  logic last_stall;

  // Reference model: the stack as an array plus an integer pointer.
  logic [15:0] m_mem [DEPTH];
  int          m_sp;
  bit          m_err;
  bit          int_pending;
  logic [2:0]  m_flags;
  logic        m_int_en;
  logic [2:0]  m_int_addr;
  logic [15:0] m_int_data;

  logic        e_stall, e_wb_valid, e_wb_en, e_pc_load;
  logic [2:0]  e_wb_addr;
  logic [15:0] e_wb_data, e_pc_target;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_sp        = DEPTH - 1;
    m_err       = 1'b0;
    int_pending = 1'b0;
    e_stall     = 1'b0;
    e_wb_valid  = 1'b0;
    e_wb_en     = 1'b0;
    e_pc_load   = 1'b0;
    e_wb_addr   = '0;
    e_wb_data   = '0;
    e_pc_target = '0;
  endtask

  task automatic modelPush(input logic [15:0] d);
    m_mem[m_sp] = d;
    if (m_sp == 0) m_err = 1'b1;
    m_sp = (m_sp + DEPTH - 1) % DEPTH;
  endtask

  task automatic modelPop(output logic [15:0] d);
    if (m_sp == DEPTH - 1) m_err = 1'b1;
    m_sp = (m_sp + 1) % DEPTH;
    d = m_mem[m_sp];
  endtask

  task automatic modelStep();
    logic [15:0] d;
    int          a;
    e_wb_valid = 1'b0;
    e_wb_en    = 1'b0;
    e_pc_load  = 1'b0;
    if (int_pending) begin
      modelPush({13'b0, m_flags});
      int_pending = 1'b0;
      e_wb_valid  = 1'b1;
      e_wb_en     = m_int_en;
      e_wb_addr   = m_int_addr;
      e_wb_data   = m_int_data;
    end else if (in_valid && mem_op != OP_NOP) begin
      a          = int'(alu_result[AW-1:0]);
      e_wb_valid = 1'b1;
      e_wb_en    = wb_en_in;
      e_wb_addr  = wb_addr_in;
      e_wb_data  = alu_result;
      case (mem_op)
        OP_LOAD:  e_wb_data = m_mem[a];
        OP_STORE: begin m_mem[a] = store_data; e_wb_en = 1'b0; end
        OP_PUSH:  modelPush(store_data);
        OP_POP:   begin modelPop(d); e_wb_data = d; end
        OP_CALL:  modelPush(pc_in);
        OP_RET:   begin modelPop(d); e_pc_target = d; e_pc_load = 1'b1; end
        OP_INT: begin
          modelPush(pc_in);
          int_pending = 1'b1;
          m_flags     = flags_in;
          m_int_en    = wb_en_in;
          m_int_addr  = wb_addr_in;
          m_int_data  = alu_result;
          e_wb_valid  = 1'b0;
          e_wb_en     = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  // Called just after a rising edge; drives one cycle and advances the model at the next edge.
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [15:0] alu,
                               input logic [15:0] sd, input logic [15:0] pc, input logic [2:0] fl,
                               input logic en, input logic [2:0] wa);
    in_valid   = v;
    mem_op     = op;
    alu_result = alu;
    store_data = sd;
    pc_in      = pc;
    flags_in   = fl;
    wb_en_in   = en;
    wb_addr_in = wa;
    e_stall    = v && !int_pending && (op == OP_INT);
    #1 last_stall = stall;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic doOp(input logic [2:0] op, input logic [15:0] alu, input logic [15:0] d);
    applyStimulus(1'b1, op, alu, d, d, 3'b000, 1'b1, 3'd1);
  endtask

  task automatic idle();
    applyStimulus(1'b0, OP_NOP, 16'h0, 16'h0, 16'h0, 3'b000, 1'b0, 3'd0);
  endtask

  task automatic doReset();
    checking   = 1'b0;
    in_valid   = 1'b0;
    mem_op     = OP_NOP;
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_wb_en", wb_en, 0);
    checkOutput("rst_wb_addr", wb_addr, 0);
    checkOutput("rst_wb_data", wb_data, 0);
    checkOutput("rst_pc_load", pc_load, 0);
    checkOutput("rst_pc_target", pc_target, 0);
    checkOutput("rst_stack_err", stack_err, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_sp", sp_out, 2047);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 checking = 1'b1;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("stall", stall, e_stall);
      checkOutput("wb_valid", wb_valid, e_wb_valid);
      checkOutput("pc_load", pc_load, e_pc_load);
      checkOutput("pc_target", pc_target, e_pc_target);
      checkOutput("sp_out", sp_out, m_sp);
      checkOutput("stack_err", stack_err, m_err);
      if (e_wb_valid) begin
        checkOutput("wb_en", wb_en, e_wb_en);
        checkOutput("wb_addr", wb_addr, e_wb_addr);
        checkOutput("wb_data", wb_data, e_wb_data);
      end
    end
  end

  initial begin
    logic [15:0] last_alu;
    doReset();

    for (int i = 0; i < DEPTH; i++) doOp(OP_STORE, 16'(i), 16'($urandom));

    doOp(OP_STORE, 16'h0010, 16'hBEEF);
    checkOutput("store_wb_en", wb_en, 0);
    applyStimulus(1'b1, OP_LOAD, 16'h0010, 16'h0, 16'h0, 3'b000, 1'b1, 3'd3);
    checkOutput("load_data", wb_data, 16'hBEEF);
    checkOutput("load_addr", wb_addr, 3);
    checkOutput("load_valid", wb_valid, 1);

    doOp(OP_PUSH, 16'h0, 16'h1234);
    doOp(OP_PUSH, 16'h0, 16'h5678);
    checkOutput("push_sp", sp_out, 2045);
    doOp(OP_POP, 16'h0, 16'h0);
    checkOutput("pop1_data", wb_data, 16'h5678);
    doOp(OP_POP, 16'h0, 16'h0);
    checkOutput("pop2_data", wb_data, 16'h1234);
    checkOutput("pop_sp", sp_out, 2047);

    doOp(OP_CALL, 16'h0, 16'h0040);
    checkOutput("call_sp", sp_out, 2046);
    doOp(OP_RET, 16'h0, 16'h0);
    checkOutput("ret_pc_load", pc_load, 1);
    checkOutput("ret_pc_target", pc_target, 16'h0040);
    checkOutput("ret_sp", sp_out, 2047);
    idle();
    checkOutput("ret_pulse_end", pc_load, 0);

    applyStimulus(1'b1, OP_INT, 16'h0, 16'h0, 16'h0100, 3'b101, 1'b1, 3'd2);
    checkOutput("int_stall", last_stall, 1);
    checkOutput("int1_sp", sp_out, 2046);
    checkOutput("int1_valid", wb_valid, 0);
    applyStimulus(1'b1, 3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  3'($urandom), 1'($urandom), 3'($urandom));
    checkOutput("int2_stall", last_stall, 0);
    checkOutput("int2_sp", sp_out, 2045);
    checkOutput("int2_valid", wb_valid, 1);
    idle();
    checkOutput("int_after_stall", last_stall, 0);
    checkOutput("int_after_valid", wb_valid, 0);
    doOp(OP_POP, 16'h0, 16'h0);
    checkOutput("int_flags_word", wb_data, 16'h0005);
    doOp(OP_POP, 16'h0, 16'h0);
    checkOutput("int_pc_word", wb_data, 16'h0100);
    checkOutput("int_sp_back", sp_out, 2047);

    doOp(OP_POP, 16'h0, 16'h0);
    checkOutput("wrap_sp", sp_out, 0);
    checkOutput("wrap_err", stack_err, 1);
    repeat (3) idle();
    checkOutput("err_sticky", stack_err, 1);

    doReset();
    last_alu = 16'h0;
    for (int i = 0; i < RANDOM_CYCLES; i++) begin
      logic [15:0] alu;
      alu = ($urandom_range(0, 3) == 0) ? last_alu : 16'($urandom);
      last_alu = alu;
      applyStimulus(($urandom_range(0, 9) != 0), 3'($urandom), alu, 16'($urandom),
                    16'($urandom), 3'($urandom), 1'($urandom), 3'($urandom));
    end

    doReset();
    doOp(OP_STORE, 16'h07FE, 16'h1111);
    applyStimulus(1'b1, OP_INT, 16'h0, 16'h0, 16'hABCD, 3'b010, 1'b1, 3'd1);
    doReset();
    applyStimulus(1'b1, OP_LOAD, 16'h07FF, 16'h0, 16'h0, 3'b000, 1'b1, 3'd4);
    checkOutput("midint_pc_word", wb_data, 16'hABCD);
    applyStimulus(1'b1, OP_LOAD, 16'h07FE, 16'h0, 16'h0, 3'b000, 1'b1, 3'd4);
    checkOutput("midint_no_flags", wb_data, 16'h1111);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
